stream_pack: RTL and testbench
==============================

Name: stream_pack

Overview:
- Consumer-side companion to the valid/ready FIFO: drains a narrow DATA_W beat stream (typically a FIFO b-port) and packs PACK_N consecutive beats into one wide word on a valid/ready output.
- An optional a_last flushes a partial word early.
- Full throughput: one input beat accepted per cycle when the downstream never stalls.

Parameters:
- DATA_W, 8, width of one input beat / one output lane.
- PACK_N, 4, beats per output word; legal range 1..64.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- a_data  in  DATA_W  input beat.
- a_valid  in  1  input beat present.
- a_ready  out  1  block accepts beat this cycle.
- a_last  in  1  beat closes the current word; sampled only on accept.
- b_data  out  PACK_N*DATA_W  packed word; lane k = bits [k*DATA_W +: DATA_W].
- b_count  out  $clog2(PACK_N+1)  number of filled lanes, 1..PACK_N.
- b_last  out  1  word was closed by a_last.
- b_valid  out  1  packed word present.
- b_ready  in  1  downstream accepts word.

Behaviour:
- Reset (nrst low, asynchronous assert, synchronous-to-clk release):
  - state=FILL, lane index=0.
  - b_valid=0, b_data=0, b_count=0, b_last=0.
  - a_ready forced 0 while nrst low.
- Handshakes:
  - Input accept = a_valid & a_ready.
  - Output accept = b_valid & b_ready.
  - b_data, b_count and b_last are stable while b_valid=1 and b_ready=0.
  - b_valid never drops without an output accept.
- Lane order:
  - First accepted beat of a word goes to lane 0 (LSBs); beat i goes to lane i.
  - Unfilled lanes read 0.
- State FILL (b_valid=0):
  - a_ready=1.
  - On accept: write lane idx, b_count=idx+1.
  - If idx==PACK_N-1 or a_last=1: go HOLD next cycle (b_valid=1), b_last=a_last, idx=0.
  - Otherwise: idx+1.
- State HOLD (b_valid=1):
  - a_ready=b_ready (combinational pass-through; no bubble).
  - Output accept with no input accept: go FILL, clear b_data/b_count/b_last.
  - Output accept with simultaneous input accept: new beat goes to lane 0, lanes 1..PACK_N-1 cleared, b_count=1.
    - Stay HOLD if PACK_N==1 or a_last=1 (b_last=a_last).
    - Else go FILL with idx=1.
  - No output accept: no change; input not accepted.
- Latency: the final beat of a word is accepted in cycle t; b_valid=1 in cycle t+1.
- PACK_N==1: every beat is a full word; block acts as a 1-deep registered slice with full throughput.
- a_last on the beat that also fills lane PACK_N-1: b_count=PACK_N, b_last=1; no empty extra word.
- a_last is ignored when a_valid=0 or a_ready=0.
- b_ready asserted while b_valid=0 has no effect.
- Reset mid-word: the partial word is discarded; no output is generated for it after reset release.

Test Plan:
- PACK_N=4, DATA_W=8, b_ready=1. Stream 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 back-to-back -> words 0x44332211 then 0x88776655, each b_count=4, b_last=0. a_ready=1 every cycle; one word every 4 cycles.
- Send 0xA1,0xA2 with a_last on 0xA2 -> b_data=0x0000A2A1, b_count=2, b_last=1. Next word starts in lane 0.
- Hold b_ready=0 for 5 cycles after word 0x04030201 forms while a_valid stays 1 with 0x05 -> a_ready=0, b_* stable. Release b_ready -> 0x05 accepted the same cycle into lane 0; next word 0x08070605.
- PACK_N=1 with random b_ready (50%) over 200 beats 0x00..0xC7 -> output sequence identical to input, b_count=1 always, no loss or duplication, no bubble whenever b_ready=1.
- Drop nrst for 1 cycle after 2 of 4 beats (0x01,0x02) -> outputs zero immediately. After release, beats 0x09..0x0C yield a single 0x0C0B0A09; no word contains 0x01 or 0x02.
- a_last on 4th beat (0xD1..0xD4) -> b_data=0xD4D3D2D1, b_count=4, b_last=1, exactly one word emitted.

Source files
------------

// File: rtl/stream_pack.sv
// Packs PACK_N narrow input beats into one wide valid/ready output word.
// An accepted a_last closes a partially filled word early.
module stream_pack_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] lane_q, lane_d;

  always_comb begin
    lane_d = lane_q;
    if (wr)       lane_d = d;
    else if (clr) lane_d = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) lane_q <= '0;
    else       lane_q <= lane_d;
  end

  assign q = lane_q;
endmodule

module stream_pack #(
  parameter int DATA_W = 8,
  parameter int PACK_N = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic                         a_last,
  output logic [PACK_N*DATA_W-1:0]     b_data,
  output logic [$clog2(PACK_N+1)-1:0]  b_count,
  output logic                         b_last,
  output logic                         b_valid,
  input  logic                         b_ready
);
  localparam int CNT_W  = $clog2(PACK_N+1);
  localparam int IDX_W  = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam bit SINGLE = (PACK_N == 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           last_q, last_d;
  logic                           in_acc, out_acc;
  logic [PACK_N-1:0]              lane_wr, lane_clr;
  logic [PACK_N-1:0][DATA_W-1:0]  lane_q;

  assign b_valid = (state_q == HOLD);
  // HOLD passes b_ready straight through so a word can drain and refill in one cycle
  assign a_ready = nrst & ((state_q == FILL) | b_ready);
  assign in_acc  = a_valid & a_ready;
  assign out_acc = b_valid & b_ready;

  always_comb begin
    lane_wr  = '0;
    lane_clr = '0;
    for (int k = 0; k < PACK_N; k++) begin
      if (state_q == FILL) lane_wr[k] = in_acc & (idx_q == IDX_W'(k));
      else                 lane_wr[k] = in_acc & (k == 0);
      lane_clr[k] = out_acc & ~lane_wr[k];
    end
  end

  for (genvar g = 0; g < PACK_N; g++) begin : g_lane
    stream_pack_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .nrst (nrst),
      .wr   (lane_wr[g]),
      .clr  (lane_clr[g]),
      .d    (a_data),
      .q    (lane_q[g])
    );
  end

  assign b_data  = lane_q;
  assign b_count = count_q;
  assign b_last  = last_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      FILL: begin
        if (in_acc) begin
          count_d = CNT_W'(idx_q) + CNT_W'(1);
          if (idx_q == IDX_W'(PACK_N-1) || a_last) begin
            state_d = HOLD;
            last_d  = a_last;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_acc) begin
          if (in_acc) begin
            count_d = CNT_W'(1);
            if (SINGLE || a_last) begin
              last_d = a_last;
            end else begin
              state_d = FILL;
              last_d  = 1'b0;
              idx_d   = IDX_W'(1);
            end
          end else begin
            state_d = FILL;
            count_d = '0;
            last_d  = 1'b0;
            idx_d   = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_stream_pack.sv
// Scoreboard bench for stream_pack: a PACK_N=4 instance driven from a vector
// table plus corner sequences, and a PACK_N=1 instance under random backpressure.
module tb_stream_pack;
  logic clk, nrst;

  logic [7:0]  a_data4;
  logic        a_valid4, a_ready4, a_last4;
  logic [31:0] b_data4;
  logic [2:0]  b_count4;
  logic        b_last4, b_valid4, b_ready4;

  logic [7:0]  a_data1;
  logic        a_valid1, a_ready1, a_last1;
  logic [7:0]  b_data1;
  logic [0:0]  b_count1;
  logic        b_last1, b_valid1, b_ready1;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] w; logic [2:0] c; logic e; } exp_t;
  typedef struct { logic [7:0] d; logic l; logic p; logic [31:0] w; logic [2:0] c; logic e; } vec_t;

  exp_t       q4[$];
  logic [7:0] q1[$];
  vec_t       tbl[$];

  stream_pack #(.DATA_W(8), .PACK_N(4)) dut4 (
    .clk(clk), .nrst(nrst), .a_data(a_data4), .a_valid(a_valid4), .a_ready(a_ready4),
    .a_last(a_last4), .b_data(b_data4), .b_count(b_count4), .b_last(b_last4),
    .b_valid(b_valid4), .b_ready(b_ready4));

  stream_pack #(.DATA_W(8), .PACK_N(1)) dut1 (
    .clk(clk), .nrst(nrst), .a_data(a_data1), .a_valid(a_valid1), .a_ready(a_ready1),
    .a_last(a_last1), .b_data(b_data1), .b_count(b_count1), .b_last(b_last1),
    .b_valid(b_valid1), .b_ready(b_ready1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic l, input logic p,
                              input logic [31:0] w, input logic [2:0] c, input logic e);
    vec_t v;
    v.d = d; v.l = l; v.p = p; v.w = w; v.c = c; v.e = e;
    return v;
  endfunction

  // Output monitors: pop one expected word per output handshake
  always @(negedge clk) begin
    if (nrst && b_valid4 && b_ready4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL p4_unexpected_word: got %h expected none", b_data4);
      end else begin
        exp_t x;
        x = q4.pop_front();
        chk("p4_word", b_data4, x.w);
        chk("p4_count", {29'd0, b_count4}, {29'd0, x.c});
        chk("p4_last", {31'd0, b_last4}, {31'd0, x.e});
      end
    end
  end

  always @(negedge clk) begin
    if (nrst && b_valid1 && b_ready1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL p1_unexpected_word: got %h expected none", b_data1);
      end else begin
        logic [7:0] x;
        x = q1.pop_front();
        chk("p1_word", {24'd0, b_data1}, {24'd0, x});
        chk("p1_count", {31'd0, b_count1}, 32'd1);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat
  task automatic beat4(input vec_t v, input bit must_ready);
    int w;
    w = 0;
    a_data4 = v.d; a_last4 = v.l; a_valid4 = 1'b1;
    @(negedge clk);
    while (!a_ready4 && w < 100) begin
      w++;
      @(negedge clk);
    end
    if (!a_ready4) begin
      checks++; failures++;
      $display("FAIL p4_accept_timeout: got a_ready=0 expected 1 for beat %h", v.d);
    end else if (v.p) begin
      exp_t x;
      x.w = v.w; x.c = v.c; x.e = v.e;
      q4.push_back(x);
    end
    if (must_ready) chk("p4_no_stall", w, 0);
    @(posedge clk); #1;
    a_valid4 = 1'b0; a_last4 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, q4.size() + q1.size(), 0);
  endtask

  initial begin
    int sent, cyc;
    nrst = 0;
    a_data4 = 0; a_valid4 = 0; a_last4 = 0; b_ready4 = 1;
    a_data1 = 0; a_valid1 = 0; a_last1 = 0; b_ready1 = 0;

    tbl.push_back(mk(8'h11, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h22, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h33, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h44, 0, 1, 32'h44332211, 3'd4, 0));
    tbl.push_back(mk(8'h55, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h66, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h77, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'h88, 0, 1, 32'h88776655, 3'd4, 0));
    tbl.push_back(mk(8'hA1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hA2, 1, 1, 32'h0000A2A1, 3'd2, 1));
    tbl.push_back(mk(8'hD1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hD2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hD3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(8'hD4, 1, 1, 32'hD4D3D2D1, 3'd4, 1));

    // Reset state
    #12;
    chk("rst_b_valid4", {31'd0, b_valid4}, 0);
    chk("rst_b_data4", b_data4, 0);
    chk("rst_b_count4", {29'd0, b_count4}, 0);
    chk("rst_b_last4", {31'd0, b_last4}, 0);
    chk("rst_a_ready4", {31'd0, a_ready4}, 0);
    chk("rst_a_ready1", {31'd0, a_ready1}, 0);
    chk("rst_b_valid1", {31'd0, b_valid1}, 0);
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;

    // Back-to-back stream, early-close word, last-on-full word
    foreach (tbl[i]) beat4(tbl[i], 1'b1);
    drain("table_drain");

    // Downstream stall while a beat waits
    b_ready4 = 0;
    for (int i = 1; i <= 4; i++)
      beat4(mk(8'(i), 0, (i == 4), 32'h04030201, 3'd4, 0), 1'b1);
    a_data4 = 8'h05; a_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_a_ready", {31'd0, a_ready4}, 0);
      chk("stall_b_valid", {31'd0, b_valid4}, 1);
      chk("stall_b_data", b_data4, 32'h04030201);
      chk("stall_b_count", {29'd0, b_count4}, 4);
      @(posedge clk); #1;
    end
    b_ready4 = 1;
    @(negedge clk);
    chk("release_a_ready", {31'd0, a_ready4}, 1);
    @(posedge clk); #1;
    a_valid4 = 1'b0;
    beat4(mk(8'h06, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h07, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h08, 0, 1, 32'h08070605, 3'd4, 0), 1'b1);
    drain("stall_drain");

    // Reset mid-word discards the partial word
    beat4(mk(8'h01, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h02, 0, 0, 0, 0, 0), 1'b1);
    nrst = 0;
    #1;
    chk("midrst_b_data", b_data4, 0);
    chk("midrst_b_valid", {31'd0, b_valid4}, 0);
    chk("midrst_b_count", {29'd0, b_count4}, 0);
    chk("midrst_a_ready", {31'd0, a_ready4}, 0);
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;
    beat4(mk(8'h09, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h0A, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h0B, 0, 0, 0, 0, 0), 1'b1);
    beat4(mk(8'h0C, 0, 1, 32'h0C0B0A09, 3'd4, 0), 1'b1);
    drain("reset_drain");

    // PACK_N=1 slice under random backpressure
    sent = 0; cyc = 0;
    while ((sent < 200 || q1.size() != 0) && cyc < 3000) begin
      b_ready1 = 1'($urandom_range(0, 1));
      a_valid1 = (sent < 200);
      a_data1  = 8'(sent);
      @(negedge clk);
      if (b_ready1) chk("p1_no_bubble", {31'd0, a_ready1}, 1);
      if (a_valid1 && a_ready1) begin
        q1.push_back(8'(sent));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    a_valid1 = 0; b_ready1 = 0;
    chk("p1_all_sent", sent, 200);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
